// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg
//   Shared constants for the register pipeline: default datapath width and
//   depth, and the width of the occupancy count.
package reg_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Bits needed to count 0..depth valid stages.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_word.sv
// reg_word
//   WIDTH-bit register with asynchronous reset, synchronous load enable and
//   synchronous clear. Clear wins over load.
//   CLK   in   clock, rising edge
//   RST   in   asynchronous reset, active-high, loads RST_VAL
//   CLR   in   synchronous clear to RST_VAL
//   LOAD  in   load D on the next edge
//   D     in   WIDTH  next value
//   Q     out  WIDTH  registered value
module reg_word #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (CLR) begin
         data_d = RST_VAL;
      end else if (LOAD) begin
         data_d = D;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_q <= RST_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign Q = data_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe
//   DEPTH-stage WIDTH-bit register pipeline with valid/ready flow control,
//   bubble collapsing and a synchronous flush.
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active-high
//   CLR        in   synchronous flush, active-high
//   IN_VALID   in   upstream data valid
//   IN_READY   out  pipeline accepts IN_DATA this cycle
//   IN_DATA    in   WIDTH upstream data
//   OUT_VALID  out  last stage valid
//   OUT_READY  in   downstream accepts OUT_DATA
//   OUT_DATA   out  WIDTH last stage data
//   OCCUPANCY  out  number of valid stages
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter int               DEPTH   = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        CLR,
   input  logic                        IN_VALID,
   output logic                        IN_READY,
   input  logic [WIDTH-1:0]            IN_DATA,
   output logic                        OUT_VALID,
   input  logic                        OUT_READY,
   output logic [WIDTH-1:0]            OUT_DATA,
   output logic [occ_width(DEPTH)-1:0] OCCUPANCY
);

   localparam int OCC_W = occ_width(DEPTH);

   logic [DEPTH-1:0] v;
   logic [DEPTH:0]   rdy;
   logic [DEPTH-1:0] xfer;
   logic [WIDTH-1:0] d [DEPTH];
   logic [OCC_W-1:0] occ;

   // A stage can take new data if it is empty or its contents move on this
   // cycle; this is what lets empty stages fill behind a stalled output.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = OUT_READY;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy[i] = !v[i] || rdy[i+1];
      end
   end

   assign IN_READY = rdy[0] && !CLR;

   always_comb begin
      xfer    = '0;
      xfer[0] = IN_VALID && IN_READY;
      for (int i = 1; i < DEPTH; i++) begin
         xfer[i] = v[i-1] && rdy[i];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [WIDTH-1:0] din;

      if (g == 0) begin : g_first
         assign din = IN_DATA;
      end else begin : g_next
         assign din = d[g-1];
      end

      reg_word #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_data (
         .CLK  (CLK),
         .RST  (RST),
         .CLR  (CLR),
         .LOAD (xfer[g]),
         .D    (din),
         .Q    (d[g])
      );

      // Whenever the stage is ready its valid flag takes the incoming
      // transfer: set on arrival, cleared when the item left with nothing
      // behind it.
      reg_word #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
         .CLK  (CLK),
         .RST  (RST),
         .CLR  (CLR),
         .LOAD (rdy[g]),
         .D    (xfer[g]),
         .Q    (v[g])
      );
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ = occ + OCC_W'(v[i]);
      end
   end

   assign OUT_VALID = v[DEPTH-1];
   assign OUT_DATA  = d[DEPTH-1];
   assign OCCUPANCY = occ;

endmodule

// File: tb/tb_reg_pipe.sv
module tb_reg_pipe;

   logic clk;
   logic rst;
   logic clr;

   // main instance: DEPTH=4, WIDTH=8, RST_VAL=0x5A
   logic       iv, ir, ov, ordy;
   logic [7:0] id, od;
   logic [2:0] occ;

   // sweep instance: DEPTH=1, WIDTH=1
   logic       s1_iv, s1_ir, s1_ov, s1_or;
   logic [0:0] s1_id, s1_od;
   logic [0:0] s1_occ;

   // sweep instance: DEPTH=8, WIDTH=32, RST_VAL=0xDEADBEEF
   logic        s8_iv, s8_ir, s8_ov, s8_or;
   logic [31:0] s8_id, s8_od;
   logic [3:0]  s8_occ;

   int n_chk;
   int n_err;

   reg_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h5A)) u_dut (
      .CLK(clk), .RST(rst), .CLR(clr),
      .IN_VALID(iv), .IN_READY(ir), .IN_DATA(id),
      .OUT_VALID(ov), .OUT_READY(ordy), .OUT_DATA(od),
      .OCCUPANCY(occ)
   );

   reg_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_dut_d1 (
      .CLK(clk), .RST(rst), .CLR(clr),
      .IN_VALID(s1_iv), .IN_READY(s1_ir), .IN_DATA(s1_id),
      .OUT_VALID(s1_ov), .OUT_READY(s1_or), .OUT_DATA(s1_od),
      .OCCUPANCY(s1_occ)
   );

   reg_pipe #(.WIDTH(32), .DEPTH(8), .RST_VAL(32'hDEADBEEF)) u_dut_d8 (
      .CLK(clk), .RST(rst), .CLR(clr),
      .IN_VALID(s8_iv), .IN_READY(s8_ir), .IN_DATA(s8_id),
      .OUT_VALID(s8_ov), .OUT_READY(s8_or), .OUT_DATA(s8_od),
      .OCCUPANCY(s8_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q1_exp [$];
   logic [31:0] q1 [$];
   logic [31:0] q8 [$];
   logic [31:0] n1;
   logic [31:0] n8;

   initial begin
      logic [7:0] stream_in [4];
      logic [7:0] stream_out [8];
      logic       stream_ov [8];
      logic [7:0] bub_out [9];

      n_chk = 0;
      n_err = 0;
      rst = 1'b1; clr = 1'b0;
      iv = 1'b0; id = '0; ordy = 1'b0;
      s1_iv = 1'b0; s1_id = '0; s1_or = 1'b0;
      s8_iv = 1'b0; s8_id = '0; s8_or = 1'b0;
      n1 = '0; n8 = '0;

      repeat (2) step();
      #1;
      chk("rst_ov", ov, 0);
      chk("rst_od", od, 8'h5A);
      chk("rst_occ", occ, 0);
      chk("rst_ir", ir, 1);
      chk("rst_d8_od", s8_od, 32'hDEADBEEF);
      rst = 1'b0;
      step();

      // ---------- streaming, OUT_READY=1 ----------
      stream_in  = '{8'h11, 8'h22, 8'h33, 8'h44};
      stream_ov  = '{0, 0, 0, 1, 1, 1, 1, 0};
      stream_out = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      ordy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         iv = (k < 4);
         id = (k < 4) ? stream_in[k] : 8'h00;
         #1;
         if (k < 4) chk($sformatf("str_ir%0d", k), ir, 1);
         step();
         chk($sformatf("str_ov%0d", k), ov, stream_ov[k]);
         if (stream_ov[k]) chk($sformatf("str_od%0d", k), od, stream_out[k]);
      end
      iv = 1'b0;

      // ---------- backpressure ----------
      ordy = 1'b0;
      for (int k = 0; k < 6; k++) begin
         iv = 1'b1;
         id = 8'((k + 1) * 8'h11);
         #1;
         chk($sformatf("bp_ir%0d", k), ir, (k < 4) ? 1 : 0);
         if (k >= 4) begin
            chk($sformatf("bp_ov%0d", k), ov, 1);
            chk($sformatf("bp_stall_od%0d", k), od, 8'h11);
         end
         step();
      end
      iv = 1'b0;
      #1;
      chk("bp_occ", occ, 4);
      chk("bp_ir_full", ir, 0);
      ordy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("bp_drain_ov%0d", k), ov, 1);
         chk($sformatf("bp_drain_od%0d", k), od, 8'((k + 1) * 8'h11));
         step();
      end
      chk("bp_empty_ov", ov, 0);
      chk("bp_empty_occ", occ, 0);

      // ---------- bubble collapse + simultaneous push/pop ----------
      ordy = 1'b0;
      iv = 1'b1; id = 8'hA1;
      step();
      iv = 1'b0;
      repeat (5) step();
      chk("bub_single_ov", ov, 1);
      chk("bub_single_occ", occ, 1);
      for (int k = 0; k < 3; k++) begin
         iv = 1'b1;
         id = 8'hB1 + 8'(k);
         #1;
         chk($sformatf("bub_ir%0d", k), ir, 1);
         step();
      end
      #1;
      chk("bub_full_occ", occ, 4);
      chk("bub_head_od", od, 8'hA1);
      bub_out = '{8'hA1, 8'hB1, 8'hB2, 8'hB3, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      ordy = 1'b1;
      for (int j = 0; j < 9; j++) begin
         iv = (j < 5);
         id = 8'hC1 + 8'(j);
         #1;
         if (j < 5) chk($sformatf("pp_ir%0d", j), ir, 1);
         chk($sformatf("pp_occ%0d", j), occ, (j <= 5) ? 4 : 9 - j);
         chk($sformatf("pp_ov%0d", j), ov, 1);
         chk($sformatf("pp_od%0d", j), od, bub_out[j]);
         step();
      end
      iv = 1'b0;
      chk("pp_end_ov", ov, 0);
      chk("pp_end_occ", occ, 0);

      // ---------- CLR mid-stream ----------
      ordy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         iv = 1'b1;
         id = 8'hD1 + 8'(k);
         step();
      end
      chk("clr_pre_occ", occ, 3);
      clr = 1'b1; iv = 1'b1; id = 8'hEE;
      #1;
      chk("clr_ir", ir, 0);
      step();
      clr = 1'b0; iv = 1'b0;
      chk("clr_occ", occ, 0);
      chk("clr_ov", ov, 0);
      chk("clr_od", od, 8'h5A);
      ordy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("clr_none%0d", k), ov, 0);
      end

      // ---------- RST asserted mid-cycle with items in flight ----------
      ordy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         iv = 1'b1;
         id = 8'hF1 + 8'(k);
         step();
      end
      iv = 1'b0;
      chk("mrst_pre_occ", occ, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_ov", ov, 0);
      chk("mrst_od", od, 8'h5A);
      chk("mrst_occ", occ, 0);
      chk("mrst_ir", ir, 1);
      rst = 1'b0;
      step();
      ordy = 1'b1;
      repeat (5) step();
      chk("mrst_no_output", ov, 0);

      // ---------- random scoreboard sweep ----------
      for (int c = 0; c < 10000; c++) begin
         s1_iv = 1'($urandom_range(0, 1));
         s1_or = 1'($urandom_range(0, 1));
         s1_id = n1[0];
         s8_iv = ($urandom_range(0, 3) != 0);
         s8_or = ($urandom_range(0, 2) != 0);
         s8_id = {n8[15:0], ~n8[15:0]};
         #1;
         chk("s1_occ", s1_occ, q1.size());
         chk("s1_ir", s1_ir, (q1.size() < 1) || s1_or);
         chk("s8_occ", s8_occ, q8.size());
         chk("s8_ir", s8_ir, (q8.size() < 8) || s8_or);
         if (s1_ov && s1_or) begin
            if (q1.size() == 0) chk("s1_spurious", 1, 0);
            else chk("s1_data", s1_od, q1.pop_front());
         end
         if (s8_ov && s8_or) begin
            if (q8.size() == 0) chk("s8_spurious", 1, 0);
            else chk("s8_data", s8_od, q8.pop_front());
         end
         if (s1_iv && s1_ir) begin
            q1.push_back({31'd0, n1[0]});
            n1 = n1 + 1;
         end
         if (s8_iv && s8_ir) begin
            q8.push_back({n8[15:0], ~n8[15:0]});
            n8 = n8 + 1;
         end
         step();
      end
      s1_iv = 1'b0; s8_iv = 1'b0;
      s1_or = 1'b1; s8_or = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (s1_ov) begin
            if (q1.size() == 0) chk("s1_drain_spurious", 1, 0);
            else chk("s1_drain", s1_od, q1.pop_front());
         end
         if (s8_ov) begin
            if (q8.size() == 0) chk("s8_drain_spurious", 1, 0);
            else chk("s8_drain", s8_od, q8.pop_front());
         end
         step();
      end
      chk("s1_left", q1.size(), 0);
      chk("s8_left", q8.size(), 0);
      chk("s8_moved", (n8 > 32'd1000), 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
